karatsuba_seq_22bit: RTL and testbench
======================================

Name: karatsuba_seq_22bit

Overview:
- Sequencer that computes a 22x22-bit GF(2) (carry-less) product, giving a 43-bit result.
- Time-shares one external HALFxHALF carry-less multiplier across the three Karatsuba sub-products: low, high, middle.
- Performs the middle-term correction and the 11-bit-offset overlap combine internally.
- Sits between an operand producer and the 163-bit Karatsuba tree as a low-area replacement for three parallel sub-multipliers.

Parameters:
- HALF, 11, half-operand width; operand width 2*HALF, sub-product width 2*HALF-1, result width 4*HALF-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  2*HALF  operand A.
- in_b  input  2*HALF  operand B.
- mul_a  output  HALF  operand A to shared multiplier.
- mul_b  output  HALF  operand B to shared multiplier.
- mul_p  input  2*HALF-1  product returned by shared multiplier.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  4*HALF-1  carry-less product A*B.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid=0; out_data=0; mul_a=0; mul_b=0; busy=0; in_ready=1; internal registers cleared.
- States: IDLE -> MUL_LO -> MUL_HI -> MUL_MID -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: register a=in_a, b=in_b; go to MUL_LO.
  - in_ready is 0 in every other state, so there is never more than one operation in flight.
- MUL_LO:
  - mul_a=a[HALF-1:0], mul_b=b[HALF-1:0].
  - Capture p_lo=mul_p at end of cycle.
- MUL_HI:
  - mul_a=a[2H-1:H], mul_b=b[2H-1:H].
  - Capture p_hi=mul_p.
- MUL_MID:
  - mul_a=a_lo^a_hi, mul_b=b_lo^b_hi.
  - mid=mul_p^p_lo^p_hi.
  - out_data <= p_lo ^ (mid<<HALF) ^ (p_hi<<2*HALF), zero-extended to 4*HALF-1 bits; all additions are XOR.
- DONE:
  - out_valid=1; out_data held stable until out_ready.
  - On out_ready: out_valid=0 next cycle, return to IDLE.
- mul_a/mul_b are 0 in IDLE and DONE.
- Latency: handshake cycle T, out_valid high from T+4. Throughput: one result per 5 cycles with out_ready tied high.
- in_valid while busy is ignored; in_a/in_b may change freely after acceptance.
- Reset mid-operation: operation is abandoned, no out_valid pulse, in_ready=1 after release.
- out_ready while out_valid=0 has no effect.
- mul_p is treated as combinational, sampled in the same cycle its operands are presented.

Optional Feature:
- Macro: KS_SEQ_MUL_REG_EN.
- Defined: the shared multiplier has a 1-cycle registered output.
  - Each MUL_* state lasts 2 cycles, tracked by a phase bit: present operands in phase 0, sample mul_p in phase 1.
  - mul_a/mul_b are held across both phases.
  - Latency becomes T+7; throughput one result per 8 cycles.
- Undefined: combinational timing as described in Behaviour.

Test Plan:
- Reset, then in_a=0x000001, in_b=0x000001 -> out_valid at T+4, out_data=0x1; busy high T+1..T+4.
- in_a=0x3FFFFF, in_b=0x000001 -> out_data=0x3FFFFF.
- in_a=0x200000, in_b=0x200000 -> out_data=1<<42.
- in_a=0x000003, in_b=0x000003 -> out_data=0x5 (carry-less). Also in_a=in_b=0x000801 -> mul_a=mul_b=0 in MUL_MID, out_data=0x400001.
- Backpressure:
  - Hold out_ready=0 for 6 cycles -> out_valid and out_data stable, in_ready=0, a new in_valid is not accepted.
  - Release out_ready -> IDLE next cycle.
- Reset mid-operation: assert rst_n=0 during MUL_HI -> out_valid=0 and busy=0 immediately.
  - After release, in_a=0x000002, in_b=0x000003 -> out_data=0x6.
  - Repeat the suite with KS_SEQ_MUL_REG_EN defined; out_valid at T+7.

Source files
------------

// File: rtl/karatsuba_seq_22bit.sv
// ---------------------------------------------------------------------------
// karatsuba_seq_22bit
//
// Purpose:
//   Computes the 22x22-bit carry-less (GF(2)) product of two operands, giving
//   a 43-bit result. One external HALFxHALF carry-less multiplier is shared
//   across the three Karatsuba sub-products (low, high, middle). The middle
//   term correction and the HALF-bit-offset overlap combine are done here.
//
//   Sequence: IDLE -> MUL_LO -> MUL_HI -> MUL_MID -> DONE -> IDLE.
//   Only one operation is ever in flight; in_ready is high only in IDLE.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. in_ready is registered and high only in
//   IDLE. out_valid is registered; out_data is held stable while
//   out_valid=1 and out_ready=0. out_ready while out_valid=0 does nothing.
//
// Optional build macro: KS_SEQ_MUL_REG_EN
//   Undefined (default): mul_p is combinational, sampled in the same cycle
//     its operands are presented. Latency T+4, one result per 5 cycles.
//   Defined: the shared multiplier has a 1-cycle registered output. Every
//     MUL_* state lasts two cycles (phase 0 presents operands, phase 1
//     samples mul_p). Latency T+7, one result per 8 cycles.
//
// Parameters:
//   HALF      half-operand width (default 11)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  block can accept operands (IDLE only)
//   in_a       in   [2*HALF-1:0] operand A
//   in_b       in   [2*HALF-1:0] operand B
//   mul_a      out  [HALF-1:0]   operand A to shared multiplier
//   mul_b      out  [HALF-1:0]   operand B to shared multiplier
//   mul_p      in   [2*HALF-2:0] product from shared multiplier
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   out_data   out  [4*HALF-2:0] carry-less product A*B
//   busy       out  high in any state other than IDLE
// ---------------------------------------------------------------------------
module karatsuba_seq_22bit #(
   parameter int HALF = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*HALF-1:0]     in_a,
   input  logic [2*HALF-1:0]     in_b,
   output logic [HALF-1:0]       mul_a,
   output logic [HALF-1:0]       mul_b,
   input  logic [2*HALF-2:0]     mul_p,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*HALF-2:0]     out_data,
   output logic                  busy
);

   localparam int OW = 2 * HALF;       // operand width
   localparam int PW = 2 * HALF - 1;   // sub-product width
   localparam int RW = 4 * HALF - 1;   // result width

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MUL_LO  = 3'd1,
      S_MUL_HI  = 3'd2,
      S_MUL_MID = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t            state;
   logic [OW-1:0]     a_q;
   logic [OW-1:0]     b_q;
   logic [PW-1:0]     p_lo;
   logic [PW-1:0]     p_hi;

   // Operand halves of the captured pair.
   logic [HALF-1:0]   a_lo;
   logic [HALF-1:0]   a_hi;
   logic [HALF-1:0]   b_lo;
   logic [HALF-1:0]   b_hi;

   // Middle term and final combine, evaluated while mul_p holds the
   // (a_lo^a_hi)*(b_lo^b_hi) product.
   logic [PW-1:0]     mid;
   logic [RW-1:0]     combined;

   // High in the cycle where mul_p carries the product for the operands
   // currently held on mul_a/mul_b.
   logic              sample;

`ifdef KS_SEQ_MUL_REG_EN
   // 0: operands presented, 1: registered product available.
   logic              phase;
   assign sample = phase;
`else
   assign sample = 1'b1;
`endif

   assign a_lo = a_q[HALF-1:0];
   assign a_hi = a_q[OW-1:HALF];
   assign b_lo = b_q[HALF-1:0];
   assign b_hi = b_q[OW-1:HALF];

   // Karatsuba over GF(2): (a_lo^a_hi)(b_lo^b_hi) = lo ^ hi ^ cross terms,
   // so XOR-ing p_lo and p_hi back out leaves the cross terms alone.
   assign mid = mul_p ^ p_lo ^ p_hi;

   // Overlapping combine: the three terms sit at bit offsets 0, HALF and
   // 2*HALF and overlap by HALF-1 bits, all merged with XOR.
   assign combined = RW'(p_lo)
                   ^ (RW'(mid)  << HALF)
                   ^ (RW'(p_hi) << (2 * HALF));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         p_lo      <= '0;
         p_hi      <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
`ifdef KS_SEQ_MUL_REG_EN
         phase     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
`ifdef KS_SEQ_MUL_REG_EN
               phase <= 1'b0;
`endif
               if (in_valid) begin
                  a_q      <= in_a;
                  b_q      <= in_b;
                  // Outputs are registered, so the low-half operands are
                  // loaded here to be on the bus during MUL_LO.
                  mul_a    <= in_a[HALF-1:0];
                  mul_b    <= in_b[HALF-1:0];
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_MUL_LO;
               end
            end

            S_MUL_LO: begin
`ifdef KS_SEQ_MUL_REG_EN
               phase <= ~phase;
`endif
               if (sample) begin
                  p_lo  <= mul_p;
                  mul_a <= a_hi;
                  mul_b <= b_hi;
                  state <= S_MUL_HI;
               end
            end

            S_MUL_HI: begin
`ifdef KS_SEQ_MUL_REG_EN
               phase <= ~phase;
`endif
               if (sample) begin
                  p_hi  <= mul_p;
                  mul_a <= a_lo ^ a_hi;
                  mul_b <= b_lo ^ b_hi;
                  state <= S_MUL_MID;
               end
            end

            S_MUL_MID: begin
`ifdef KS_SEQ_MUL_REG_EN
               phase <= ~phase;
`endif
               if (sample) begin
                  out_data  <= combined;
                  out_valid <= 1'b1;
                  mul_a     <= '0;
                  mul_b     <= '0;
                  state     <= S_DONE;
               end
            end

            S_DONE: begin
               // out_data is untouched here, so it stays stable under
               // backpressure.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: begin
               state     <= S_IDLE;
               mul_a     <= '0;
               mul_b     <= '0;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
`ifdef KS_SEQ_MUL_REG_EN
               phase     <= 1'b0;
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_karatsuba_seq_22bit.sv
// ---------------------------------------------------------------------------
// tb_karatsuba_seq_22bit
//
// Bench for karatsuba_seq_22bit. Provides the shared 11x11 carry-less
// multiplier (combinational, or 1-cycle registered when KS_SEQ_MUL_REG_EN is
// defined), drives operand pairs, and checks results against a direct 22x22
// carry-less reference through an expected queue popped by a monitor.
// ---------------------------------------------------------------------------
module tb_karatsuba_seq_22bit;

`ifdef KS_SEQ_MUL_REG_EN
   localparam int MULC = 2;
   localparam int LAT  = 7;
`else
   localparam int MULC = 1;
   localparam int LAT  = 4;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [21:0] in_a;
   logic [21:0] in_b;
   logic [10:0] mul_a;
   logic [10:0] mul_b;
   logic [20:0] mul_p;
   logic        out_valid;
   logic        out_ready;
   logic [42:0] out_data;
   logic        busy;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   karatsuba_seq_22bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   // ---------------- models ----------------
   function automatic logic [20:0] clmul11(logic [10:0] a, logic [10:0] b);
      logic [20:0] r = '0;
      for (int i = 0; i < 11; i++)
         if (b[i]) r ^= (21'(a) << i);
      return r;
   endfunction

   function automatic logic [42:0] clmul22(logic [21:0] a, logic [21:0] b);
      logic [42:0] r = '0;
      for (int i = 0; i < 22; i++)
         if (b[i]) r ^= (43'(a) << i);
      return r;
   endfunction

`ifdef KS_SEQ_MUL_REG_EN
   always @(posedge clk) mul_p <= clmul11(mul_a, mul_b);
`else
   always_comb mul_p = clmul11(mul_a, mul_b);
`endif

   // ---------------- scoreboard ----------------
   logic [42:0] exp_q[$];
   int          lat_q[$];
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: latency on out_valid rise, stability under backpressure,
   // data compare on each output handshake.
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [42:0] prev_data  = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (lat_q.size() == 0) begin
               check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               check("latency", 64'(cyc - lat_q.pop_front()), 64'(LAT));
            end
         end
         if (out_valid && prev_valid && !prev_ready)
            check("out_data_stable", 64'(out_data), 64'(prev_data));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
               check("result_without_request", 64'(out_valid), 64'd0);
            else
               check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
      end
   end

   // ---------------- driver tasks ----------------
   // Presents one operand pair and waits (bounded) for acceptance.
   // Returns at posedge+1 of the cycle after the accepting edge.
   task automatic send(input logic [21:0] a, input logic [21:0] b,
                       input logic [42:0] e);
      int waited = 0;
      @(posedge clk);
      #1;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
      end else begin
         exp_q.push_back(e);
         lat_q.push_back(cyc);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_a     = 22'($urandom);
         in_b     = 22'($urandom);
      end
   endtask

   // Sends one pair with out_ready high and checks the operand bus, busy
   // and in_ready on every cycle of the operation.
   task automatic run_op(input logic [21:0] a, input logic [21:0] b,
                         input logic [42:0] e);
      logic [10:0] ea;
      logic [10:0] eb;
      send(a, b, e);
      for (int k = 1; k <= 3 * MULC; k++) begin
         @(negedge clk);
         case ((k - 1) / MULC)
            0:       begin ea = a[10:0];            eb = b[10:0];            end
            1:       begin ea = a[21:11];           eb = b[21:11];           end
            default: begin ea = a[10:0] ^ a[21:11]; eb = b[10:0] ^ b[21:11]; end
         endcase
         check("mul_a", 64'(mul_a), 64'(ea));
         check("mul_b", 64'(mul_b), 64'(eb));
         check("busy_op", 64'(busy), 64'd1);
         check("in_ready_op", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      check("busy_done", 64'(busy), 64'd1);
      check("out_valid_done", 64'(out_valid), 64'd1);
      check("mul_a_done", 64'(mul_a), 64'd0);
      @(negedge clk);
      check("out_valid_idle", 64'(out_valid), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
      check("in_ready_idle", 64'(in_ready), 64'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_busy"},      64'(busy),      64'd0);
      check({tag, "_in_ready"},  64'(in_ready),  64'd1);
      check({tag, "_mul_a"},     64'(mul_a),     64'd0);
      check({tag, "_mul_b"},     64'(mul_b),     64'd0);
   endtask

   // ---------------- stimulus ----------------
   logic rnd_on = 1'b0;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      check("reset_out_data", 64'(out_data), 64'd0);
      rst_n = 1'b1;

      // Directed values with hand-derived results.
      run_op(22'h000001, 22'h000001, 43'h1);
      run_op(22'h3FFFFF, 22'h000001, 43'h3FFFFF);
      run_op(22'h200000, 22'h200000, 43'd1 << 42);
      run_op(22'h000003, 22'h000003, 43'h5);
      run_op(22'h000801, 22'h000801, 43'h400001);

      // Backpressure: hold the result for 6 cycles while offering a new pair.
      out_ready = 1'b0;
      send(22'h12345, 22'h2ABCD, clmul22(22'h12345, 22'h2ABCD));
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      check("bp_out_valid_seen", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      in_a     = 22'h3F0F0F;
      in_b     = 22'h00FFFF;
      in_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_release_out_valid", 64'(out_valid), 64'd0);
      check("bp_extra_not_accepted", 64'(exp_q.size()), 64'd0);

      // Reset during MUL_HI abandons the operation.
      send(22'h1FFFFF, 22'h155555, 43'h0);
      repeat (MULC) @(posedge clk);
      #1;
      check("pre_reset_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      lat_q.delete();
      check_reset_state("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(22'h000002, 22'h000003, 43'h6);

      // Random operands with random output backpressure.
      rnd_on = 1'b1;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               logic [21:0] ra;
               logic [21:0] rb;
               ra = 22'($urandom);
               rb = 22'($urandom);
               if (n % 8 == 0) ra = '0;
               if (n % 8 == 1) rb = 22'h3FFFFF;
               send(ra, rb, clmul22(ra, rb));
               repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      #1;
      out_ready = 1'b1;
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
